key_mode_select: RTL and testbench

//  Four-button mode selector for the smart-car top level. Four raw active-low push-buttons
//  are synchronised and debounced. A qualified press on button N registers mode N on sel_type.
//  sel_type drives the downstream drive/behaviour mode mux.

---
 rtl/key_mode_select_pkg.sv | 26 ++
 rtl/key_mode_select_debounce.sv | 51 +++++
 rtl/key_mode_select.sv | 48 ++++
 tb/tb_key_mode_select.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/key_mode_select_pkg.sv
// Shared mode encoding for the smart-car mode selector and the downstream mode mux.
// Also holds the fixed-priority pick used when several buttons qualify in the same cycle.
package key_mode_select_pkg;

  localparam int MODE_W = 2;
  localparam int N_KEYS = 4;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_0 = 2'd0;
  localparam mode_t MODE_1 = 2'd1;
  localparam mode_t MODE_2 = 2'd2;
  localparam mode_t MODE_3 = 2'd3;

  // Lowest key index wins when several press pulses coincide
  function automatic mode_t pick_mode(input logic [N_KEYS-1:0] press);
    mode_t m;
    m = MODE_0;
    if (press[0])      m = MODE_0;
    else if (press[1]) m = MODE_1;
    else if (press[2]) m = MODE_2;
    else if (press[3]) m = MODE_3;
    return m;
  endfunction

endpackage

// File: rtl/key_mode_select_debounce.sv
// One active-low push-button: 2-flop synchroniser, stable-level debounce counter and
// a registered one-cycle pulse on each accepted press (stable level falling 1->0).
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int CNT_W        = 20
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_press,
  output logic key_level
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_stable   <= 1'b1;
      r_stable_d <= 1'b1;
      r_cnt      <= '0;
      r_press    <= 1'b0;
    end else begin
      r_sync1    <= key_in;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_press    <= r_stable_d & ~r_stable;
      // Any sample that agrees with the stable level restarts the qualification window
      if (r_sync2 != r_stable) begin
        if (r_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
          r_stable <= r_sync2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign key_press = r_press;
  assign key_level = r_stable;

endmodule

// File: rtl/key_mode_select.sv
// Four-button mode selector: each raw button is debounced independently and a qualified
// press on button N registers mode N on sel_type, lowest index winning on a tie.
module key_mode_select
  import key_mode_select_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int CNT_W        = 20
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              key0,
  input  logic              key1,
  input  logic              key2,
  input  logic              key3,
  output logic [MODE_W-1:0] sel_type
);

  logic [N_KEYS-1:0] w_keys;
  logic [N_KEYS-1:0] w_press;
  logic [N_KEYS-1:0] w_unused_level;
  mode_t             r_sel;

  assign w_keys = {key3, key2, key1, key0};

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .CNT_W       (CNT_W)
    ) u_deb (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .key_in   (w_keys[g]),
      .key_press(w_press[g]),
      .key_level(w_unused_level[g])
    );
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sel <= MODE_0;
    end else if (|w_press) begin
      r_sel <= pick_mode(w_press);
    end
  end

  assign sel_type = r_sel;

endmodule

// File: tb/tb_key_mode_select.sv
// Bench for key_mode_select with a short debounce window; a cycle model of the buttons
// predicts each sel_type change (value and cycle) into a queue checked by a monitor.
module tb_key_mode_select;

  localparam int DB = 5;

  logic       clk;
  logic       rst;
  logic [3:0] keys;
  logic [1:0] sel_type;

  key_mode_select #(
    .DEBOUNCE_CYC(DB),
    .CNT_W       (4)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .key0    (keys[0]),
    .key1    (keys[1]),
    .key2    (keys[2]),
    .key3    (keys[3]),
    .sel_type(sel_type)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    int cyc;
    int mode;
  } exp_t;

  exp_t       q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         chg_cyc = 0;
  bit         mon_en  = 1'b0;
  logic [1:0] last_sel;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: a level is accepted after DB consecutive differing synchronised samples
  logic m_s1[4], m_s2[4], m_st[4];
  int   m_run[4];
  int   m_mode = 0;

  initial begin
    int win;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        for (int k = 0; k < 4; k++) begin
          m_s1[k] = 1'b1; m_s2[k] = 1'b1; m_st[k] = 1'b1; m_run[k] = 0;
        end
        while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
        if (m_mode != 0) q.push_back('{cyc: cyc, mode: 0});
        m_mode = 0;
      end else begin
        win = -1;
        for (int k = 0; k < 4; k++) begin
          if (m_s2[k] != m_st[k]) begin
            m_run[k]++;
            if (m_run[k] == DB) begin
              m_st[k]  = m_s2[k];
              m_run[k] = 0;
              if (m_s2[k] == 1'b0 && win < 0) win = k;
            end
          end else begin
            m_run[k] = 0;
          end
          m_s2[k] = m_s1[k];
          m_s1[k] = keys[k];
        end
        // stable edge -> press pulse one cycle later -> sel_type one cycle after that
        if (win >= 0 && win != m_mode) begin
          q.push_back('{cyc: cyc + 2, mode: win});
          m_mode = win;
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && sel_type !== last_sel) begin
        chg_cyc = cyc;
        if (q.size() == 0) begin
          chk("unexpected_change", sel_type, last_sel);
        end else begin
          e = q.pop_front();
          chk("change_value", sel_type, e.mode);
          chk("change_cycle", cyc, e.cyc);
        end
        last_sel = sel_type;
      end
    end
  end

  task automatic step(input logic [3:0] v, input int n);
    keys = v;
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int         s;
    logic [3:0] v;
    int         order[4] = '{0, 1, 3, 2};

    rst  = 1'b1;
    keys = 4'hF;
    @(negedge clk);
    #1;
    rst      = 1'b0;
    last_sel = sel_type;
    mon_en   = 1'b1;

    // 1: reset and idle
    chk("t1_reset", sel_type, 0);
    step(4'hF, 100);
    chk("t1_idle", sel_type, 0);
    chk("t1_queue", q.size(), 0);

    // 2: key1 glitches, stable low, bouncy release
    repeat (4) begin
      step(4'hD, 1);
      step(4'hF, 1);
    end
    s = cyc;
    step(4'hD, 9);
    step(4'hF, 1);
    step(4'hD, 1);
    step(4'hF, 1);
    step(4'hD, 1);
    step(4'hF, 20);
    chk("t2_latency_ok", (chg_cyc - s >= 9 && chg_cyc - s <= 10), 1);
    chk("t2_sel", sel_type, 1);
    chk("t2_queue", q.size(), 0);

    // 3: key2 bounces only
    for (int i = 0; i < 20; i++) step((i % 2 == 0) ? 4'hB : 4'hF, 1);
    step(4'hF, 20);
    chk("t3_sel", sel_type, 1);
    chk("t3_queue", q.size(), 0);

    // 4: sequence 0,1,3,2
    for (int i = 0; i < 4; i++) begin
      v = 4'hF ^ (4'b0001 << order[i]);
      step(v, 10);
      step(4'hF, 10);
      chk($sformatf("t4_sel_key%0d", order[i]), sel_type, order[i]);
      chk("t4_queue", q.size(), 0);
    end

    // 5: key1 and key3 together, then key3 held alone
    step(4'h5, 10);
    chk("t5_priority", sel_type, 1);
    step(4'h7, 20);
    chk("t5_hold", sel_type, 1);
    chk("t5_queue", q.size(), 0);
    step(4'hF, 15);

    // 6: reset mid-press on key2
    step(4'hB, 3);
    rst = 1'b1;
    step(4'hB, 1);
    rst = 1'b0;
    chk("t6_after_reset", sel_type, 0);
    step(4'hB, 12);
    chk("t6_fresh_press", sel_type, 2);
    step(4'hF, 15);
    chk("t6_sel", sel_type, 2);
    chk("t6_queue", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
